// File: rtl/dmi_access_ctrl_if.sv
// DMI request/response channel between the DTM access controller and the debug module.
// Package dm carries the DMI payload types shared by both ends of the channel.
package dm;
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

interface dmi_access_ctrl_if;
    logic          dmi_req_valid_o;
    logic          dmi_req_ready_i;
    dm::dmi_req_t  dmi_req_o;
    logic          dmi_resp_valid_i;
    logic          dmi_resp_ready_o;
    dm::dmi_resp_t dmi_resp_i;

    modport master (
        output dmi_req_valid_o,
        input  dmi_req_ready_i,
        output dmi_req_o,
        input  dmi_resp_valid_i,
        output dmi_resp_ready_o,
        input  dmi_resp_i
    );

    modport slave (
        input  dmi_req_valid_o,
        output dmi_req_ready_i,
        input  dmi_req_o,
        output dmi_resp_valid_i,
        input  dmi_resp_ready_o,
        output dmi_resp_i
    );
endinterface

// File: rtl/dmi_access_ctrl.sv
// DTM-side DMI access controller: turns Update-DR scans into DM requests and tracks dmistat.
// Optional response watchdog enabled by defining DMI_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no DMI transaction outstanding, scans accepted
// REQ       | request presented to the DM, waiting for ready
// WAIT_RESP | request accepted, waiting for the DM response
module dmi_access_ctrl #(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        update_i,
    input  logic        capture_i,
    input  logic [1:0]  dr_op_i,
    input  logic [6:0]  dr_addr_i,
    input  logic [31:0] dr_data_i,
    input  logic        dmireset_i,
    input  logic        dmihardreset_i,
    output logic [1:0]  capture_op_o,
    output logic [6:0]  capture_addr_o,
    output logic [31:0] capture_data_o,
    output logic [1:0]  dmistat_o,
    output logic        dmi_rst_no,
    dmi_access_ctrl_if.master dmi
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_e;

    state_e       state_q, state_d;
    logic [1:0]   dmistat_q, dmistat_d;
    dm::dmi_req_t req_q, req_d;
    logic [31:0]  cap_data_q, cap_data_d;
    logic         cap_busy_q, cap_busy_d;
    logic         rst_n_q;
    logic         accept, busy_evt, resp_hs, timeout;

`ifdef DMI_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;

    // Preloaded while outside WAIT_RESP so it starts fresh on every entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q != WAIT_RESP) begin
            cnt_q <= CntW'(TimeoutCycles - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign timeout = (state_q == WAIT_RESP) && (cnt_q == '0) && !dmi.dmi_resp_valid_i
                     && !dmihardreset_i;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles > 0);
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dmistat_d  = dmistat_q;
        req_d      = req_q;
        cap_data_d = cap_data_q;
        cap_busy_d = cap_busy_q;

        busy_evt = (update_i || capture_i) && (state_q != IDLE);
        accept   = (state_q == IDLE) && update_i && !dmireset_i && !dmihardreset_i
                   && (dmistat_q == 2'd0) && (dr_op_i == 2'd1 || dr_op_i == 2'd2);
        resp_hs  = (state_q == WAIT_RESP) && dmi.dmi_resp_valid_i && !dmihardreset_i;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d   = '{addr: dr_addr_i, op: dr_op_i, data: dr_data_i};
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dmi.dmi_req_ready_i) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (resp_hs) begin
                    state_d = IDLE;
                    if (req_q.op == 2'd1) cap_data_d = dmi.dmi_resp_i.data;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // First error wins: only a clean status can pick up a new one.
        if (dmistat_q == 2'd0) begin
            if (resp_hs && dmi.dmi_resp_i.resp[1]) dmistat_d = dmi.dmi_resp_i.resp;
            else if (timeout)                      dmistat_d = 2'd2;
            else if (busy_evt)                     dmistat_d = 2'd3;
        end

        if (capture_i) cap_busy_d = (state_q != IDLE);

        if (dmireset_i) begin
            dmistat_d  = 2'd0;
            cap_busy_d = 1'b0;
        end

        if (dmihardreset_i) begin
            state_d    = IDLE;
            dmistat_d  = 2'd0;
            cap_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            dmistat_q  <= 2'd0;
            req_q      <= '0;
            cap_data_q <= '0;
            cap_busy_q <= 1'b0;
            rst_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            dmistat_q  <= dmistat_d;
            req_q      <= req_d;
            cap_data_q <= cap_data_d;
            cap_busy_q <= cap_busy_d;
            rst_n_q    <= !(dmihardreset_i || timeout);
        end
    end

    assign dmi.dmi_req_valid_o  = (state_q == REQ);
    assign dmi.dmi_req_o        = req_q;
    assign dmi.dmi_resp_ready_o = (state_q == WAIT_RESP);

    assign capture_op_o   = cap_busy_q ? 2'd3 : dmistat_q;
    assign capture_addr_o = req_q.addr;
    assign capture_data_o = cap_data_q;
    assign dmistat_o      = dmistat_q;
    assign dmi_rst_no     = rst_n_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Directed bench for dmi_access_ctrl; the watchdog case adapts when DMI_TIMEOUT_EN is defined.
module tb_dmi_access_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        update_i, capture_i, dmireset_i, dmihardreset_i;
    logic [1:0]  dr_op_i;
    logic [6:0]  dr_addr_i;
    logic [31:0] dr_data_i;
    logic [1:0]  capture_op_o, dmistat_o;
    logic [6:0]  capture_addr_o;
    logic [31:0] capture_data_o;
    logic        dmi_rst_no;

    int n_chk  = 0;
    int n_fail = 0;

    dmi_access_ctrl_if dmi();

    dmi_access_ctrl #(.TimeoutCycles(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .update_i       (update_i),
        .capture_i      (capture_i),
        .dr_op_i        (dr_op_i),
        .dr_addr_i      (dr_addr_i),
        .dr_data_i      (dr_data_i),
        .dmireset_i     (dmireset_i),
        .dmihardreset_i (dmihardreset_i),
        .capture_op_o   (capture_op_o),
        .capture_addr_o (capture_addr_o),
        .capture_data_o (capture_data_o),
        .dmistat_o      (dmistat_o),
        .dmi_rst_no     (dmi_rst_no),
        .dmi            (dmi)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic scan(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        update_i  = 1'b1;
        dr_op_i   = op;
        dr_addr_i = addr;
        dr_data_i = data;
        tick();
        update_i  = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic [1:0] resp);
        dmi.dmi_resp_valid_i = 1'b1;
        dmi.dmi_resp_i       = '{data: data, resp: resp};
        tick();
        dmi.dmi_resp_valid_i = 1'b0;
    endtask

    initial begin
        int wait_cycles;
        int rst_pulses;
        rst_i = 1'b1;
        update_i = 1'b0; capture_i = 1'b0; dmireset_i = 1'b0; dmihardreset_i = 1'b0;
        dr_op_i = 2'd0; dr_addr_i = 7'd0; dr_data_i = 32'd0;
        dmi.dmi_req_ready_i = 1'b0;
        dmi.dmi_resp_valid_i = 1'b0;
        dmi.dmi_resp_i = '0;
        tick(); tick();
        rst_i = 1'b0;

        check("rst_dmistat",  dmistat_o, 2'd0);
        check("rst_valid",    dmi.dmi_req_valid_o, 1'b0);
        check("rst_rready",   dmi.dmi_resp_ready_o, 1'b0);
        check("rst_rst_no",   dmi_rst_no, 1'b1);
        check("rst_capture",  {capture_op_o, capture_addr_o, capture_data_o}, 41'd0);
        check("rst_req",      dmi.dmi_req_o, 41'd0);

        // Read 0x11, immediate ready, response three cycles later
        dmi.dmi_req_ready_i = 1'b1;
        scan(2'd1, 7'h11, 32'h0);
        check("rd_valid_lat1", dmi.dmi_req_valid_o, 1'b1);
        check("rd_payload",    dmi.dmi_req_o, {7'h11, 2'd1, 32'h0});
        tick();
        check("rd_valid_drop", dmi.dmi_req_valid_o, 1'b0);
        check("rd_rready",     dmi.dmi_resp_ready_o, 1'b1);
        tick(); tick();
        respond(32'hDEADBEEF, 2'd0);
        check("rd_rready_off", dmi.dmi_resp_ready_o, 1'b0);
        capture_i = 1'b1; tick(); capture_i = 1'b0;
        check("rd_cap_op",   capture_op_o, 2'd0);
        check("rd_cap_addr", capture_addr_o, 7'h11);
        check("rd_cap_data", capture_data_o, 32'hDEADBEEF);

        // Write with ready held low five cycles
        dmi.dmi_req_ready_i = 1'b0;
        scan(2'd2, 7'h04, 32'h1);
        for (int i = 0; i < 5; i++) begin
            check("wr_valid_hold",   dmi.dmi_req_valid_o, 1'b1);
            check("wr_payload_hold", dmi.dmi_req_o, {7'h04, 2'd2, 32'h1});
            tick();
        end
        dmi.dmi_req_ready_i = 1'b1;
        check("wr_valid_6th", dmi.dmi_req_valid_o, 1'b1);
        tick();
        check("wr_valid_after", dmi.dmi_req_valid_o, 1'b0);
        respond(32'h12345678, 2'd0);
        check("wr_cap_data_kept", capture_data_o, 32'hDEADBEEF);
        check("wr_cap_addr",      capture_addr_o, 7'h04);

        // nop and reserved ops issue nothing
        scan(2'd0, 7'h05, 32'h0);
        check("nop_valid", dmi.dmi_req_valid_o, 1'b0);
        scan(2'd3, 7'h06, 32'h0);
        check("op3_valid", dmi.dmi_req_valid_o, 1'b0);
        check("op3_addr",  capture_addr_o, 7'h04);

        // Busy update during WAIT_RESP, then response colliding with another busy update
        scan(2'd1, 7'h20, 32'h0);
        tick();
        scan(2'd1, 7'h21, 32'h0);
        check("busy_dmistat", dmistat_o, 2'd3);
        check("busy_addr",    capture_addr_o, 7'h20);
        check("busy_valid",   dmi.dmi_req_valid_o, 1'b0);
        update_i = 1'b1; dr_addr_i = 7'h22;
        respond(32'hCAFE0001, 2'd0);
        update_i = 1'b0;
        check("coll_rready",  dmi.dmi_resp_ready_o, 1'b0);
        check("coll_data",    capture_data_o, 32'hCAFE0001);
        check("coll_dmistat", dmistat_o, 2'd3);
        scan(2'd1, 7'h23, 32'h0);
        check("sticky_valid", dmi.dmi_req_valid_o, 1'b0);
        check("sticky_addr",  capture_addr_o, 7'h20);
        dmireset_i = 1'b1;
        scan(2'd1, 7'h24, 32'h0);
        dmireset_i = 1'b0;
        check("dmireset_stat",  dmistat_o, 2'd0);
        check("dmireset_valid", dmi.dmi_req_valid_o, 1'b0);
        scan(2'd1, 7'h25, 32'h0);
        check("recover_valid", dmi.dmi_req_valid_o, 1'b1);
        tick();
        respond(32'h0BADF00D, 2'd0);
        check("recover_data", capture_data_o, 32'h0BADF00D);
        check("recover_addr", capture_addr_o, 7'h25);

        // Failed response
        scan(2'd1, 7'h30, 32'h0);
        tick();
        respond(32'h11112222, 2'd2);
        check("fail_dmistat", dmistat_o, 2'd2);
        check("fail_cap_op",  capture_op_o, 2'd2);
        scan(2'd1, 7'h31, 32'h0);
        check("fail_noreq",   dmi.dmi_req_valid_o, 1'b0);
        check("fail_sticky",  dmistat_o, 2'd2);

        // Busy capture in REQ, then hardreset
        dmireset_i = 1'b1; tick(); dmireset_i = 1'b0;
        dmi.dmi_req_ready_i = 1'b0;
        scan(2'd1, 7'h40, 32'h0);
        capture_i = 1'b1; tick(); capture_i = 1'b0;
        check("bcap_op",      capture_op_o, 2'd3);
        check("bcap_dmistat", dmistat_o, 2'd3);
        check("bcap_valid",   dmi.dmi_req_valid_o, 1'b1);
        dmihardreset_i = 1'b1; tick(); dmihardreset_i = 1'b0;
        check("hrst_valid",   dmi.dmi_req_valid_o, 1'b0);
        check("hrst_rst_no",  dmi_rst_no, 1'b0);
        check("hrst_dmistat", dmistat_o, 2'd0);
        check("hrst_cap_op",  capture_op_o, 2'd0);
        tick();
        check("hrst_rst_no_1cyc", dmi_rst_no, 1'b1);

        // Unanswered request: watchdog expiry or indefinite wait
        dmi.dmi_req_ready_i = 1'b1;
        scan(2'd1, 7'h50, 32'h0);
        tick();
        wait_cycles = 0;
        rst_pulses  = 0;
        for (int i = 0; i < 40; i++) begin
            if (dmi.dmi_resp_ready_o) wait_cycles++;
            if (!dmi_rst_no) rst_pulses++;
            tick();
        end
`ifdef DMI_TIMEOUT_EN
        check("to_wait_cycles", wait_cycles, 16);
        check("to_rst_pulses",  rst_pulses, 1);
        check("to_dmistat",     dmistat_o, 2'd2);
        check("to_idle",        dmi.dmi_resp_ready_o, 1'b0);
`else
        check("nto_wait_cycles", wait_cycles, 40);
        check("nto_rst_pulses",  rst_pulses, 0);
        check("nto_dmistat",     dmistat_o, 2'd0);
        respond(32'h0, 2'd0);
        check("nto_idle", dmi.dmi_resp_ready_o, 1'b0);
`endif

        // rst_i mid-transaction abandons without a FIFO clear pulse
        dmireset_i = 1'b1; tick(); dmireset_i = 1'b0;
        scan(2'd1, 7'h60, 32'h0);
        tick();
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        check("mrst_rready", dmi.dmi_resp_ready_o, 1'b0);
        check("mrst_rst_no", dmi_rst_no, 1'b1);
        check("mrst_addr",   capture_addr_o, 7'h00);
        tick();
        check("mrst_rst_no_after", dmi_rst_no, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmi_access_ctrl.md
DMI_ACCESS_CTRL -- requirements
Module: dmi_access_ctrl

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 256, DMI response watchdog limit in cycles; used only with DMI_TIMEOUT_EN.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic sits on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port update_i, input, 1, one-cycle pulse: the DR fields below are a new DMI scan (Update-DR).
REQ-005 SHALL have port capture_i, input, 1, one-cycle pulse: the TAP is loading capture_*_o (Capture-DR).
REQ-006 SHALL have ports dr_op_i (2), dr_addr_i (7) and dr_data_i (32), all inputs, the scanned-in DMI op, address and data.
REQ-007 SHALL have ports dmireset_i and dmihardreset_i, inputs, 1 each, dtmcs clear pulses.
REQ-008 SHALL have ports capture_op_o (2), capture_addr_o (7) and capture_data_o (32), all outputs, the value returned on the next scan.
REQ-009 SHALL have port dmistat_o, output, 2, sticky status: 0 ok, 2 failed, 3 busy.
REQ-010 SHALL have port dmi_rst_no, output, 1, active-low clear to the DM response FIFO.
REQ-011 SHALL have ports dmi_req_valid_o (output, 1), dmi_req_ready_i (input, 1) and dmi_req_o (output, dm::dmi_req_t), the request channel to the DM.
REQ-012 SHALL have ports dmi_resp_valid_i (input, 1), dmi_resp_ready_o (output, 1) and dmi_resp_i (input, dm::dmi_resp_t), the response channel from the DM.

Function
REQ-013 SHALL implement FSM states IDLE, REQ and WAIT_RESP.
REQ-014 IDLE, update_i with dmistat 0 and op 1 (read) or op 2 (write): SHALL latch addr/op/data and enter REQ; dmi_req_valid_o is high from the next cycle (latency 1).
REQ-015 IDLE, update_i with op 0 or op 3, or with dmistat nonzero: SHALL issue no request and change no state.
REQ-016 REQ: dmi_req_valid_o SHALL stay high with a stable payload until a cycle with dmi_req_ready_i high, then the FSM enters WAIT_RESP; valid never drops without a handshake except on hardreset or reset.
REQ-017 WAIT_RESP: dmi_resp_ready_o SHALL be high and is low in all other states; on dmi_resp_valid_i the FSM returns to IDLE in the same cycle.
REQ-018 Response: if the operation was a read, data SHALL be stored into the capture data register; resp 2 SHALL set dmistat 2 and resp 3 SHALL set dmistat 3, only if dmistat is currently 0 (first error wins).
REQ-019 update_i or capture_i while the state is not IDLE SHALL set dmistat 3 if it is 0; a busy update SHALL be discarded.
REQ-020 capture_op_o SHALL equal dmistat_o, and SHALL be 3 if capture_i arrives while the state is not IDLE.
REQ-021 capture_addr_o SHALL hold the last accepted address; capture_data_o SHALL hold the last read data.
REQ-022 dmireset_i SHALL clear dmistat to 0 next cycle and not affect the FSM; an update_i in the same cycle SHALL be ignored.
REQ-023 dmihardreset_i SHALL force IDLE, clear dmistat, drop valid and drive dmi_rst_no low for exactly one cycle; it takes priority over every other event in the same cycle.
REQ-024 Response arriving in the same cycle as a busy update_i: SHALL complete normally and set dmistat 3.

Reset
REQ-025 rst_i SHALL put the FSM in IDLE and set dmistat 0, capture_*_o 0, dmi_req_valid_o 0, dmi_resp_ready_o 0, dmi_rst_no 1 and dmi_req_o 0, with effect on the next edge.
REQ-026 rst_i mid-transaction SHALL abandon the transaction without issuing a dmi_rst_no pulse.

Configuration
REQ-027 With DMI_TIMEOUT_EN defined: a counter SHALL run in WAIT_RESP, clear on entry, and on reaching TimeoutCycles with no response set dmistat 2 (if 0), return to IDLE and pulse dmi_rst_no low for one cycle.
REQ-028 Without DMI_TIMEOUT_EN: no counter SHALL exist, and WAIT_RESP waits indefinitely.

Verification
REQ-029 Read addr 0x11, ready immediate, resp {0xDEADBEEF, 0} after 3 cycles -> valid 1 cycle after update; capture gives op 0, addr 0x11, data 0xDEADBEEF.
REQ-030 Write addr 0x04, data 0x1, ready held low 5 cycles -> valid held with stable payload for 6 cycles; write response leaves capture_data unchanged.
REQ-031 Second update during WAIT_RESP -> no second request; dmistat 3; further updates ignored until dmireset_i, then a read succeeds.
REQ-032 DM returns resp 2 -> dmistat 2; a later busy event leaves it at 2.
REQ-033 dmihardreset_i while in REQ -> valid 0 next cycle, dmi_rst_no low exactly 1 cycle, dmistat 0.
REQ-034 DMI_TIMEOUT_EN, TimeoutCycles 16, no response -> IDLE after 16 cycles, dmistat 2, one dmi_rst_no pulse.
